alu_req_arbiter: RTL and testbench

//  Shares one 64-bit Y86-64 ALU (add/sub/and/xor) between two requesters using valid/ready handshakes.
//  - Requesters are the execute-stage issue port and the address/stack-pointer port.
//  - Round-robin arbitration grants one requester; the block executes that one operation
//    and returns a tagged result.
//  - Maintains the architectural condition-code register (ZF, SF, OF).
//  - One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_core.sv | 19 +
 rtl/alu_req_arbiter.sv | 82 ++++++++
 tb/tb_alu_req_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, condition-code type and arbiter FSM states
package alu_pkg;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_XOR = 2'b11} alu_fun_t;
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;
  localparam cc_t CC_RESET = 3'b100;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational Y86-64 ALU producing result and signed overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  alu_fun_t         fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             of
);
  localparam int M = WIDTH - 1;
  always_comb begin
    res = fun == ALU_ADD ? a + b : fun == ALU_SUB ? a - b : fun == ALU_AND ? a & b : a ^ b;
    of  = fun == ALU_ADD ? (a[M] == b[M]) && (res[M] != a[M]) :
          fun == ALU_SUB ? (a[M] != b[M]) && (res[M] != a[M]) : 1'b0;
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU between two requesters, with CC register
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = alu_pkg::CC_RESET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_setcc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_setcc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_val,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             busy
);
  state_t           state;
  logic             rr_last, setcc_q, id_q, g1, of;
  alu_fun_t         fun_q;
  logic [WIDTH-1:0] a_q, b_q, res;
  cc_t              cc;
  // req1 wins when it is the only one valid, or on a tie when req0 went last
  assign g1         = req1_valid && (!req0_valid || !rr_last);
  assign req0_ready = state == IDLE && req0_valid && !g1;
  assign req1_ready = state == IDLE && g1;
  assign busy       = state != IDLE;
  assign {cc_zf, cc_sf, cc_of} = cc;
  alu_core #(.WIDTH(WIDTH)) u_alu (.fun(fun_q), .a(a_q), .b(b_q), .res(res), .of(of));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      fun_q     <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      setcc_q   <= 1'b0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_val   <= '0;
      cc        <= cc_t'(CC_RESET);
    end else begin
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          fun_q   <= alu_fun_t'(g1 ? req1_fun : req0_fun);
          a_q     <= g1 ? req1_a : req0_a;
          b_q     <= g1 ? req1_b : req0_b;
          setcc_q <= g1 ? req1_setcc : req0_setcc;
          id_q    <= g1;
          rr_last <= g1;
          state   <= EXEC;
        end
        EXEC: begin
          rsp_val   <= res;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          if (setcc_q) cc <= '{zf: res == '0, sf: res[WIDTH-1], of: of};
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and randomized checks against a behavioural ALU/arbiter model
module tb_alu_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid, req0_ready, req0_setcc, req1_valid, req1_ready, req1_setcc;
  logic [1:0] req0_fun, req1_fun;
  logic [63:0] req0_a, req0_b, req1_a, req1_b, rsp_val;
  logic rsp_valid, rsp_ready, rsp_id, cc_zf, cc_sf, cc_of, busy;
  int passed = 0, total = 0;
  logic last;
  logic [2:0] m_cc;
  logic [3:0] seq;
  logic [1:0] p;
  logic pv[2], ps[2];
  logic [1:0] pf[2];
  logic [63:0] pa[2], pb[2];

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
    .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_val(rsp_val),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic put();
    req0_valid = pv[0]; req0_fun = pf[0]; req0_a = pa[0]; req0_b = pb[0]; req0_setcc = ps[0];
    req1_valid = pv[1]; req1_fun = pf[1]; req1_a = pa[1]; req1_b = pb[1]; req1_setcc = ps[1];
  endtask

  function automatic void model(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic o);
    logic signed [65:0] sa, sb, w;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    case (f)
      2'd0: begin r = a + b; w = sa + sb; end
      2'd1: begin r = a - b; w = sa - sb; end
      2'd2: begin r = a & b; w = $signed({{2{r[63]}}, r}); end
      default: begin r = a ^ b; w = $signed({{2{r[63]}}, r}); end
    endcase
    o = w != $signed({{2{r[63]}}, r});
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_op(input int i);
    pf[i] = 2'($urandom_range(0, 3));
    pa[i] = pick();
    pb[i] = pick();
    ps[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic set_op(input int i, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input logic s);
    pv[i] = 1'b1; pf[i] = f; pa[i] = a; pb[i] = b; ps[i] = s;
  endtask

  task automatic run_op(input int stall, input bit keep);
    int n;
    logic g, eg, o;
    logic [63:0] r;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", req0_ready || req1_ready, 1);
    if (!(req0_ready || req1_ready)) return;
    chk("one_ready", req0_ready && req1_ready, 0);
    g  = req1_ready;
    eg = (pv[0] && pv[1]) ? !last : pv[1];
    chk("grant", g, eg);
    model(pf[g], pa[g], pb[g], r, o);
    if (ps[g]) m_cc = {r == 64'h0, r[63], o};
    last = g;
    @(posedge clk); #1;
    chk("exec_state", {busy, rsp_valid}, 2'b10);
    if (keep) rand_op(g); else pv[g] = 1'b0;
    put();
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_val", rsp_val, r);
    chk("rsp_id", rsp_id, g);
    chk("cc", {cc_zf, cc_sf, cc_of}, m_cc);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_val", rsp_val, r);
      chk("stall_valid_id", {rsp_valid, rsp_id}, {1'b1, g});
      chk("stall_ready", req0_ready || req1_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rsp", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pf[i] = 0; pa[i] = 0; pb[i] = 0; ps[i] = 0;
    end
    put();
    rsp_ready = 1'b1;
    last = 1'b1;
    m_cc = 3'b100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_ready", req0_ready || req1_ready, 0);

    set_op(0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1); put();
    run_op(0, 0);
    chk("add_ovf_cc", {cc_zf, cc_sf, cc_of}, 3'b011);

    set_op(0, 2'd1, 64'd10, 64'd3, 1'b1); put();
    #1;
    n = 0;
    while (!req0_ready && n < 8) begin @(posedge clk); #1; n++; end
    chk("rst_op_accept", req0_ready, 1);
    @(posedge clk); #1;
    chk("rst_op_exec", busy, 1);
    pv[0] = 1'b0; put();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    m_cc = 3'b100;
    last = 1'b1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", rsp_valid, 0);
    end

    rand_op(0); rand_op(1); pv[0] = 1'b1; pv[1] = 1'b1; put();
    seq = 4'b0;
    for (int k = 0; k < 4; k++) begin
      run_op(0, 1);
      seq = {seq[2:0], last};
    end
    chk("contend_order", seq, 4'b0101);
    pv[0] = 1'b0; pv[1] = 1'b0; put();

    set_op(1, 2'd1, 64'd5, 64'd5, 1'b1); put();
    run_op(0, 0);
    chk("sub_zero_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    set_op(1, 2'd2, 64'hF0, 64'h0F, 1'b0); put();
    run_op(0, 0);
    chk("and_val", rsp_val, 64'h0);
    chk("and_cc_kept", {cc_zf, cc_sf, cc_of}, 3'b100);

    set_op(0, 2'd1, 64'h8000_0000_0000_0000, 64'h1, 1'b1); put();
    run_op(0, 0);
    chk("sub_ovf_val", rsp_val, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf_cc", {cc_zf, cc_sf, cc_of}, 3'b001);
    set_op(0, 2'd3, 64'hFF, 64'hFF, 1'b1); put();
    run_op(0, 0);
    chk("xor_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

    set_op(1, 2'd0, 64'd3, 64'd4, 1'b0);
    set_op(0, 2'd3, 64'h1234, 64'h00FF, 1'b1); put();
    run_op(3, 0);
    run_op(0, 0);

    for (int k = 0; k < 24; k++) begin
      p = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++)
        if (!pv[i]) begin
          pv[i] = p[i];
          if (pv[i]) rand_op(i);
        end
      put();
      run_op(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
